// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry valid/ready pipeline buffer (main + skid).
// Breaks the ready path: in_ready depends on state flops only, never on
// out_ready, while still sustaining one transfer per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous discard of all held entries
//   in_valid   upstream offers in_data
//   in_data    upstream payload (WIDTH bits)
//   in_ready   stage can accept this cycle
//   out_valid  out_data holds a valid entry
//   out_data   oldest held entry, or BUBBLE when empty
//   out_ready  downstream consumes out_data this cycle
//   stall_cnt  upstream stall-cycle count (16 bits)
//
// Optional feature: define PIPE_STAGE_BUF_STATS_EN to build the saturating
// stall counter; otherwise stall_cnt is tied to zero and has no flops.
module pipe_stage_buf #(
   parameter int unsigned         WIDTH  = 32,
   parameter logic [WIDTH-1:0]    BUBBLE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [15:0]      stall_cnt
);

   localparam int unsigned STALL_W = 16;

   // Encoding chosen so bit 1 is out_valid and bit 0 is in_ready directly.
   typedef enum logic [1:0] {
      EMPTY = 2'b01,
      ONE   = 2'b11,
      FULL  = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept;
   logic             pop;

   assign in_ready  = state_q[0];
   assign out_valid = state_q[1];
   // main is forced to BUBBLE whenever the stage goes empty, so it drives
   // out_data straight from the flops.
   assign out_data  = main_q;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Next-state and storage update.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (pop && !accept) begin
               state_d = EMPTY;
               main_d  = BUBBLE;
            end else if (accept && pop) begin
               main_d  = in_data;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
            main_d  = BUBBLE;
         end
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE;
      end
   end

   // State and storage registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_BUF_STATS_EN
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where upstream offers but is held off.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         stall_cnt_d = '0;
      end else if (in_valid && !in_ready && (stall_cnt_q != {STALL_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = STALL_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed, table-driven bench for pipe_stage_buf.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge they depend on.
module tb_pipe_stage_buf;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NVEC  = 17;

   typedef struct packed {
      logic             flush;
      logic             in_valid;
      logic [WIDTH-1:0] in_data;
      logic             out_ready;
      logic             exp_valid;
      logic [WIDTH-1:0] exp_data;
      logic             exp_ready;
      logic [15:0]      exp_stall;
   } vec_t;

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [15:0]      stall_cnt;

   int errors;
   int checks;

   vec_t vecs [NVEC];

   pipe_stage_buf #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] stall_exp(input logic [15:0] v);
`ifdef PIPE_STAGE_BUF_STATS_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk(input string name, input logic [WIDTH-1:0] act,
                      input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic ev, input logic [WIDTH-1:0] ed,
                          input logic er, input logic [15:0] es);
      chk({name, ".out_valid"}, WIDTH'(out_valid), WIDTH'(ev));
      chk({name, ".out_data"},  out_data, ed);
      chk({name, ".in_ready"},  WIDTH'(in_ready), WIDTH'(er));
      chk({name, ".stall_cnt"}, WIDTH'(stall_cnt), WIDTH'(stall_exp(es)));
   endtask

   // Drive at the falling edge, clock once, sample just after the rising edge.
   task automatic step(input logic fl, input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      //          fl    iv    in_data       ord   ev    exp_data      er    stall
      vecs[0]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 16'd0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
      vecs[2]  = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 32'h11,        1'b1, 16'd0};
      vecs[3]  = '{1'b0, 1'b1, 32'h22,        1'b0, 1'b1, 32'h11,        1'b0, 16'd0};
      vecs[4]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b1, 32'h11,        1'b0, 16'd1};
      vecs[5]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b1, 32'h11,        1'b0, 16'd2};
      vecs[6]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b1, 32'h11,        1'b0, 16'd3};
      vecs[7]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b1, 32'h11,        1'b0, 16'd4};
      vecs[8]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b1, 32'h11,        1'b0, 16'd5};
      vecs[9]  = '{1'b0, 1'b1, 32'h33,        1'b1, 1'b1, 32'h22,        1'b1, 16'd6};
      vecs[10] = '{1'b0, 1'b1, 32'h33,        1'b1, 1'b1, 32'h33,        1'b1, 16'd6};
      vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 16'd6};
      vecs[12] = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 32'h11,        1'b1, 16'd6};
      vecs[13] = '{1'b0, 1'b1, 32'h22,        1'b0, 1'b1, 32'h11,        1'b0, 16'd6};
      vecs[14] = '{1'b1, 1'b1, 32'h99,        1'b0, 1'b0, 32'h0,         1'b1, 16'd0};
      vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
      vecs[16] = '{1'b1, 1'b1, 32'h77,        1'b1, 1'b0, 32'h0,         1'b1, 16'd0};

      // Reset state, held for a couple of edges.
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 32'h0, 1'b1, 16'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < int'(NVEC); i++) begin
         step(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
         chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                 vecs[i].exp_ready, vecs[i].exp_stall);
         @(negedge clk);
      end

      // Full-rate stream: each entry visible right after its accepting edge.
      for (int i = 1; i <= 100; i++) begin
         step(1'b0, 1'b1, WIDTH'(i), 1'b1);
         chk($sformatf("stream%0d.out_valid", i), WIDTH'(out_valid), WIDTH'(1));
         chk($sformatf("stream%0d.out_data", i), out_data, WIDTH'(i));
         chk($sformatf("stream%0d.in_ready", i), WIDTH'(in_ready), WIDTH'(1));
         @(negedge clk);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      chk_all("stream_drain", 1'b0, 32'h0, 1'b1, 16'd0);
      @(negedge clk);

      // Asynchronous reset between edges while FULL.
      step(1'b0, 1'b1, 32'h11, 1'b0);
      @(negedge clk);
      step(1'b0, 1'b1, 32'h22, 1'b0);
      chk_all("pre_areset", 1'b1, 32'h11, 1'b0, 16'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk_all("areset", 1'b0, 32'h0, 1'b1, 16'd0);
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 1'b1, 32'h55, 1'b1);
      chk_all("post_areset", 1'b1, 32'h55, 1'b1, 16'd0);
      @(negedge clk);
      step(1'b0, 1'b0, '0, 1'b1);
      chk_all("post_areset_drain", 1'b0, 32'h0, 1'b1, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
